// File: rtl/servo_pkg.sv
// Shared servo limits and threshold type, also used by the position stage.
package servo_pkg;

  localparam int unsigned ThresW = 15;
  typedef logic [ThresW-1:0] thres_t;

  localparam int unsigned DefClkDiv    = 100;
  localparam int unsigned DefPeriodUs  = 20000;
  localparam int unsigned DefMinUs     = 500;
  localparam int unsigned DefMaxUs     = 2500;
  localparam int unsigned DefCenterUs  = 1500;
  localparam int unsigned DefMaxStepUs = 40;

endpackage

// File: rtl/servo_pwm_drv_if.sv
// Control/status bundle of the servo PWM driver.
interface servo_pwm_drv_if;
  import servo_pkg::*;

  logic   en;
  thres_t pwm_thres;
  logic   servo_pwm;
  thres_t cur_thres;
  logic   period_start;
  logic   clamped;

  modport master (
    output en, pwm_thres,
    input  servo_pwm, cur_thres, period_start, clamped
  );

  modport slave (
    input  en, pwm_thres,
    output servo_pwm, cur_thres, period_start, clamped
  );

endinterface

// File: rtl/servo_slew_limit.sv
// Combinational target clamp and per-period slew limiter for the applied pulse width.
module servo_slew_limit
  import servo_pkg::*;
#(
  parameter int unsigned MIN_US      = DefMinUs,
  parameter int unsigned MAX_US      = DefMaxUs,
  parameter int unsigned MAX_STEP_US = DefMaxStepUs
) (
  input  thres_t cand,
  input  thres_t cur,
  output thres_t cur_next,
  output logic   clamped
);

  logic [15:0] cand_w, cur_w, tgt_w, nxt_w;
  logic [15:0] min_w, max_w, step_w;

  always_comb begin
    cand_w  = {1'b0, cand};
    cur_w   = {1'b0, cur};
    min_w   = 16'(MIN_US);
    max_w   = 16'(MAX_US);
    step_w  = 16'(MAX_STEP_US);
    tgt_w   = cur_w;
    clamped = 1'b0;

    // A zero candidate means no request: hold the current width.
    if (cand_w == 16'd0) begin
      tgt_w = cur_w;
    end else if (cand_w < min_w) begin
      tgt_w   = min_w;
      clamped = 1'b1;
    end else if (cand_w > max_w) begin
      tgt_w   = max_w;
      clamped = 1'b1;
    end else begin
      tgt_w = cand_w;
    end

    // Downward test written as tgt+step < cur so no subtraction can wrap.
    if (tgt_w > cur_w + step_w) begin
      nxt_w = cur_w + step_w;
    end else if (tgt_w + step_w < cur_w) begin
      nxt_w = cur_w - step_w;
    end else begin
      nxt_w = tgt_w;
    end

    cur_next = nxt_w[ThresW-1:0];
  end

endmodule

// File: rtl/servo_pwm_drv.sv
// 50 Hz RC-servo pulse driver: input resync/filter, us prescaler, period counter, output register.
module servo_pwm_drv
  import servo_pkg::*;
#(
  parameter int unsigned CLK_DIV     = DefClkDiv,
  parameter int unsigned PERIOD_US   = DefPeriodUs,
  parameter int unsigned MIN_US      = DefMinUs,
  parameter int unsigned MAX_US      = DefMaxUs,
  parameter int unsigned CENTER_US   = DefCenterUs,
  parameter int unsigned MAX_STEP_US = DefMaxStepUs
) (
  input logic            clk,
  input logic            rst,
  servo_pwm_drv_if.slave bus
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DivW-1:0] div_q, div_d;
  logic [15:0]     us_q, us_d;
  thres_t          q1_q, q2_q, cand_q, cur_q, cur_next;
  logic            en_q, pwm_q, pwm_d, start_q, clamped_q, clamped_next;
  logic            us_tick, boundary;

  assign us_tick  = (div_q == DivW'(CLK_DIV - 1));
  assign boundary = us_tick && (us_q == 16'(PERIOD_US - 1));

  always_comb begin
    div_d = us_tick ? '0 : div_q + DivW'(1);
    us_d  = us_q;
    if (us_tick) begin
      us_d = (us_q == 16'(PERIOD_US - 1)) ? 16'd0 : us_q + 16'd1;
    end
    // Compares against the width latched at the last boundary only.
    pwm_d = en_q && (us_q < {1'b0, cur_q});
  end

  servo_slew_limit #(
    .MIN_US      (MIN_US),
    .MAX_US      (MAX_US),
    .MAX_STEP_US (MAX_STEP_US)
  ) u_slew (
    .cand     (cand_q),
    .cur      (cur_q),
    .cur_next (cur_next),
    .clamped  (clamped_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q     <= '0;
      us_q      <= '0;
      q1_q      <= '0;
      q2_q      <= '0;
      cand_q    <= thres_t'(CENTER_US);
      cur_q     <= thres_t'(CENTER_US);
      en_q      <= 1'b0;
      pwm_q     <= 1'b0;
      start_q   <= 1'b0;
      clamped_q <= 1'b0;
    end else begin
      div_q   <= div_d;
      us_q    <= us_d;
      pwm_q   <= pwm_d;
      start_q <= boundary;
      q1_q    <= bus.pwm_thres;
      q2_q    <= q1_q;
      // Accept only two equal consecutive samples to reject multi-bit skew.
      if (q1_q == q2_q) begin
        cand_q <= q2_q;
      end
      if (boundary) begin
        en_q      <= bus.en;
        cur_q     <= cur_next;
        clamped_q <= clamped_next;
      end
    end
  end

  assign bus.servo_pwm    = pwm_q;
  assign bus.cur_thres    = cur_q;
  assign bus.period_start = start_q;
  assign bus.clamped      = clamped_q;

endmodule
